uart_buffer: RTL and testbench
==============================

UART_BUFFER -- requirements
Module: uart_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the entry count of each FIFO; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wr_en, input, 1 bit: CPU push strobe for the TX FIFO.
REQ-005 SHALL have port wr_data, input, 8 bits: the byte to transmit.
REQ-006 SHALL have port tx_full, output, 1 bit: TX FIFO holds DEPTH entries.
REQ-007 SHALL have port rd_en, input, 1 bit: CPU pop strobe for the RX FIFO.
REQ-008 SHALL have port rd_data, output, 8 bits: show-ahead RX FIFO head, valid while rx_empty=0.
REQ-009 SHALL have port rx_empty, output, 1 bit: RX FIFO holds no entries.
REQ-010 SHALL have port overrun, output, 1 bit: sticky flag, set when a received byte was discarded.
REQ-011 SHALL have port clear_overrun, input, 1 bit: clears overrun.
REQ-012 SHALL have the UART-side ports start_tx (output, 1), tx_value (output, 8), tx_done (input, 1), rx_available (input, 1), rx_value (input, 8) and rx_clear (output, 1), connecting to the same-named ports of the UART core.

Function
REQ-013 TX FSM SHALL have the states T_IDLE, T_SEND and T_RELEASE.
REQ-014 T_IDLE with TX FIFO non-empty at a clock edge SHALL pop the head into the tx_value register and move to T_SEND; start_tx=1 is visible from that edge.
REQ-015 A wr_en at edge k into an empty FIFO with the FSM in T_IDLE SHALL give start_tx=1 and tx_value=byte from edge k+1.
REQ-016 T_SEND SHALL hold start_tx=1 and keep tx_value stable until tx_done=1 is sampled, then move to T_RELEASE with start_tx=0.
REQ-017 T_RELEASE SHALL wait for tx_done=0, then return to T_IDLE.
REQ-018 wr_en while tx_full=1 SHALL be ignored, except when an FSM pop occurs in the same cycle, in which case the push SHALL be accepted and the count is unchanged.
REQ-019 RX FSM SHALL have the states R_IDLE, R_WAIT and R_CLEAR.
REQ-020 R_IDLE SHALL move to R_WAIT when rx_available=1 is sampled.
REQ-021 R_WAIT SHALL last exactly one cycle, because rx_value is registered one cycle after rx_available rises; at its exit edge the FSM SHALL capture rx_value, push it, and move to R_CLEAR.
REQ-022 R_CLEAR SHALL drive rx_clear=1 until rx_available=0 is sampled, then return to R_IDLE with rx_clear=0.
REQ-023 When the RX FIFO is full at capture, the byte SHALL be discarded, overrun SHALL be set, and the rx_clear handshake SHALL still complete.
REQ-024 A push and a pop on the RX FIFO in the same cycle SHALL both take effect.
REQ-025 rd_en while rx_empty=1 SHALL be ignored.
REQ-026 set and clear_overrun in the same cycle SHALL leave overrun=1.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; the count SHALL be log2(DEPTH)+1 bits.
REQ-028 The TX and RX paths SHALL operate independently and concurrently.

Reset
REQ-029 rst=1 at an edge SHALL force T_IDLE and R_IDLE, empty both FIFOs, and set start_tx=0, tx_value=0, rx_clear=0, overrun=0, rx_empty=1, tx_full=0 and rd_data=0.
REQ-030 Reset mid-transfer SHALL drop start_tx and rx_clear at the next edge; no in-flight byte is retained.

Configuration
REQ-031 With macro UART_RX_FIFO_EN defined, the RX storage SHALL be a DEPTH-entry FIFO.
REQ-032 Without UART_RX_FIFO_EN, the RX storage SHALL be a single holding register: rx_empty=0 while it is held, rd_en empties it, and capture while it is held sets overrun. The TX path is unaffected.

Structure
REQ-033 Package uart_pkg SHALL hold the TX and RX state enums and the DEPTH default constant.
REQ-034 Sub-module sync_fifo (8-bit, parameterised depth, show-ahead, full/empty outputs) SHALL be instantiated for TX and, under UART_RX_FIFO_EN, for RX.

Verification
REQ-035 Reset then write 0x55: start_tx=1 and tx_value=0x55 one edge later; after tx_done pulses high then low, start_tx=0 and the FSM is back in T_IDLE.
REQ-036 Write 0x01..0x05 with DEPTH=4 and tx_done held 0: tx_full=1 after the 4th write, the 5th write is dropped, and the bytes are sent in order 0x01..0x04.
REQ-037 rx_available rises, and rx_value=0xA3 appears one cycle later: rx_clear=1 two edges after the rise, rd_data=0xA3, rx_empty=0; rx_clear=0 after rx_available falls.
REQ-038 Five RX bytes received with no rd_en: the 5th byte is dropped and overrun=1; clear_overrun then gives overrun=0.
REQ-039 Apply rst while in T_SEND and R_CLEAR: next edge gives start_tx=0, rx_clear=0, rx_empty=1 and tx_full=0.
REQ-040 Build without UART_RX_FIFO_EN, receive two bytes with no rd_en: the first byte is kept in rd_data and overrun=1.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART buffer slice.
//   DEPTH_DEFAULT : default entry count of each FIFO
//   BYTE_W        : data byte width
//   tx_state_t    : transmit handshake FSM states
//   rx_state_t    : receive handshake FSM states
package uart_pkg;

    localparam int unsigned DEPTH_DEFAULT = 4;
    localparam int unsigned BYTE_W        = 8;

    typedef enum logic [1:0] {
        T_IDLE    = 2'd0,
        T_SEND    = 2'd1,
        T_RELEASE = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_WAIT  = 2'd1,
        R_CLEAR = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_buffer_if.sv
// uart_buffer_if: handshake bundle between the buffer and the UART core.
//   start_tx     : buffer -> core, byte in tx_value is ready to send
//   tx_value     : buffer -> core, byte to send
//   tx_done      : core -> buffer, transmission finished
//   rx_available : core -> buffer, a received byte is pending
//   rx_value     : core -> buffer, received byte (valid one cycle after rx_available)
//   rx_clear     : buffer -> core, acknowledge of the received byte
// Modports: master = buffer side, slave = UART core side.
interface uart_buffer_if;
    import uart_pkg::*;

    logic              start_tx;
    logic [BYTE_W-1:0] tx_value;
    logic              tx_done;
    logic              rx_available;
    logic [BYTE_W-1:0] rx_value;
    logic              rx_clear;

    modport master (
        output start_tx,
        output tx_value,
        input  tx_done,
        input  rx_available,
        input  rx_value,
        output rx_clear
    );

    modport slave (
        input  start_tx,
        input  tx_value,
        output tx_done,
        output rx_available,
        output rx_value,
        input  rx_clear
    );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write strobe and data; a push while full is accepted
//                     only when a pop happens in the same cycle
//   pop             : read strobe, ignored while empty
//   head            : current head entry (valid while empty=0)
//   full, empty     : registered occupancy flags
module sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned WIDTH = BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             pop_ok_c;
    logic             push_ok_c;

    // Accept/reject strobes and next occupancy.
    always_comb begin
        pop_ok_c  = pop && !empty;
        push_ok_c = push && (!full || pop_ok_c);
        count_nxt = count;
        case ({push_ok_c, pop_ok_c})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage, pointers (wrap modulo DEPTH by width) and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Head of queue read straight from storage (show-ahead); memory is
    // reset so head reads zero after reset.
    assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_buffer.sv
// uart_buffer: CPU-side TX/RX byte buffering in front of a UART core.
//   clk, rst      : clock, synchronous active-high reset
//   wr_en/wr_data : CPU push into the TX FIFO; tx_full when it holds DEPTH bytes
//   rd_en/rd_data : CPU pop from RX storage (show-ahead); rx_empty when none held
//   overrun       : sticky, a received byte was discarded; clear_overrun clears it
//   uart          : handshake bundle to the UART core (master side)
// Build option: define UART_RX_FIFO_EN for a DEPTH-entry RX FIFO; otherwise RX
// storage is a single holding register. TX always uses a DEPTH-entry FIFO.
module uart_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              tx_full,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              rx_empty,
    output logic              overrun,
    input  logic              clear_overrun,
    uart_buffer_if.master     uart
);

    // ---------------- TX path ----------------
    tx_state_t         tx_state;
    tx_state_t         tx_next;
    logic              tx_empty;
    logic [BYTE_W-1:0] tx_head;
    logic              tx_pop_c;
    logic              start_tx_nxt;
    logic [BYTE_W-1:0] tx_value_nxt;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (tx_pop_c),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    // TX state register.
    always_ff @(posedge clk) begin
        if (rst) tx_state <= T_IDLE;
        else     tx_state <= tx_next;
    end

    // TX next state.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:    if (!tx_empty)     tx_next = T_SEND;
            T_SEND:    if (uart.tx_done)  tx_next = T_RELEASE;
            T_RELEASE: if (!uart.tx_done) tx_next = T_IDLE;
            default:                      tx_next = T_IDLE;
        endcase
    end

    // TX outputs: pop the head into tx_value when leaving T_IDLE.
    always_comb begin
        tx_pop_c     = 1'b0;
        start_tx_nxt = 1'b0;
        tx_value_nxt = uart.tx_value;
        case (tx_state)
            T_IDLE: begin
                if (!tx_empty) begin
                    tx_pop_c     = 1'b1;
                    start_tx_nxt = 1'b1;
                    tx_value_nxt = tx_head;
                end
            end
            T_SEND:  start_tx_nxt = !uart.tx_done;
            default: start_tx_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uart.start_tx <= 1'b0;
            uart.tx_value <= '0;
        end else begin
            uart.start_tx <= start_tx_nxt;
            uart.tx_value <= tx_value_nxt;
        end
    end

    // ---------------- RX path ----------------
    rx_state_t rx_state;
    rx_state_t rx_next;
    logic      rx_push_c;
    logic      rx_clear_nxt;
    logic      rx_drop_c;

    // RX state register.
    always_ff @(posedge clk) begin
        if (rst) rx_state <= R_IDLE;
        else     rx_state <= rx_next;
    end

    // RX next state; R_WAIT is a single cycle so rx_value has settled.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (uart.rx_available)  rx_next = R_WAIT;
            R_WAIT:                          rx_next = R_CLEAR;
            R_CLEAR: if (!uart.rx_available) rx_next = R_IDLE;
            default:                         rx_next = R_IDLE;
        endcase
    end

    // RX outputs: capture on the R_WAIT exit edge, acknowledge through R_CLEAR.
    always_comb begin
        rx_push_c    = 1'b0;
        rx_clear_nxt = 1'b0;
        case (rx_state)
            R_WAIT: begin
                rx_push_c    = 1'b1;
                rx_clear_nxt = 1'b1;
            end
            R_CLEAR: rx_clear_nxt = uart.rx_available;
            default: rx_clear_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) uart.rx_clear <= 1'b0;
        else     uart.rx_clear <= rx_clear_nxt;
    end

`ifdef UART_RX_FIFO_EN
    logic rx_full;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push_c),
        .push_data (uart.rx_value),
        .pop       (rd_en),
        .head      (rd_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // A full FIFO still accepts the byte if the CPU pops in the same cycle.
    assign rx_drop_c = rx_push_c && rx_full && !rd_en;
`else
    // Single holding register; a same-cycle read frees it for the new byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rx_empty <= 1'b1;
        end else if (rx_push_c && (rx_empty || rd_en)) begin
            rd_data  <= uart.rx_value;
            rx_empty <= 1'b0;
        end else if (rd_en) begin
            rx_empty <= 1'b1;
        end
    end

    assign rx_drop_c = rx_push_c && !rx_empty && !rd_en;
`endif

    // Sticky overrun; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)                overrun <= 1'b0;
        else if (rx_drop_c)     overrun <= 1'b1;
        else if (clear_overrun) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_uart_buffer.sv
// tb_uart_buffer: directed self-checking bench for uart_buffer (DEPTH=4).
// The bench plays the UART core through the interface slave signals.
module tb_uart_buffer;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_empty;
    logic       overrun;
    logic       clear_overrun;

    int n_cmp;
    int n_bad;

    uart_buffer_if uart ();

    uart_buffer #(
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .tx_full       (tx_full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rx_empty      (rx_empty),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .uart          (uart.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One full receive handshake; clr asserts clear_overrun on the capture edge.
    task automatic rx_byte(input logic [7:0] val, input logic clr);
        uart.rx_available = 1'b1;
        tick();
        uart.rx_value = val;
        clear_overrun = clr;
        tick();
        clear_overrun = 1'b0;
        uart.rx_available = 1'b0;
        tick();
    endtask

    // Complete the current transmit and let the FSM pop the next byte.
    task automatic tx_finish();
        uart.tx_done = 1'b1;
        tick();
        uart.tx_done = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [7:0] tx_exp [4];
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        rd_en = 1'b0;
        clear_overrun = 1'b0;
        uart.tx_done = 1'b0;
        uart.rx_available = 1'b0;
        uart.rx_value = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check_val("rst_start_tx", 32'(uart.start_tx), 32'h0);
        check_val("rst_tx_value", 32'(uart.tx_value), 32'h0);
        check_val("rst_rx_clear", 32'(uart.rx_clear), 32'h0);
        check_val("rst_overrun",  32'(overrun),       32'h0);
        check_val("rst_rx_empty", 32'(rx_empty),      32'h1);
        check_val("rst_tx_full",  32'(tx_full),       32'h0);
        check_val("rst_rd_data",  32'(rd_data),       32'h0);

        // Single byte: start_tx one edge after the push edge
        wr_en = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check_val("tx_lat0", 32'(uart.start_tx), 32'h0);
        tick();
        check_val("tx_start",  32'(uart.start_tx), 32'h1);
        check_val("tx_val55",  32'(uart.tx_value), 32'h55);
        tick();
        check_val("tx_hold", 32'(uart.start_tx), 32'h1);
        uart.tx_done = 1'b1;
        tick();
        check_val("tx_release", 32'(uart.start_tx), 32'h0);
        check_val("tx_stable",  32'(uart.tx_value), 32'h55);
        uart.tx_done = 1'b0;
        tick();
        tick();
        check_val("tx_idle", 32'(uart.start_tx), 32'h0);

        // Fill while a byte (EE) is in flight: full after 4 writes, 5th dropped
        wr_en = 1'b1;
        wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        tick();
        check_val("tx_valEE", 32'(uart.tx_value), 32'hEE);
        for (int i = 1; i <= 4; i++) begin
            logic exp_full;
            exp_full = (i == 4);
            wr_en = 1'b1;
            wr_data = 8'(i);
            tick();
            check_val("tx_fill_full", 32'(tx_full), 32'(exp_full));
        end
        wr_data = 8'h05;
        tick();
        wr_en = 1'b0;
        check_val("tx_drop5_full", 32'(tx_full), 32'h1);

        // Push 06 on the very edge the FSM pops 01 from a full FIFO
        uart.tx_done = 1'b1;
        tick();
        uart.tx_done = 1'b0;
        tick();
        wr_en = 1'b1;
        wr_data = 8'h06;
        tick();
        wr_en = 1'b0;
        check_val("tx_val01",      32'(uart.tx_value), 32'h01);
        check_val("tx_start01",    32'(uart.start_tx), 32'h1);
        check_val("tx_full_keep",  32'(tx_full),       32'h1);

        tx_exp[0] = 8'h02;
        tx_exp[1] = 8'h03;
        tx_exp[2] = 8'h04;
        tx_exp[3] = 8'h06;
        for (int i = 0; i < 4; i++) begin
            tx_finish();
            check_val("tx_order", 32'(uart.tx_value), 32'(tx_exp[i]));
        end
        check_val("tx_notfull", 32'(tx_full), 32'h0);
        tx_finish();
        check_val("tx_drained", 32'(uart.start_tx), 32'h0);

        // Receive handshake with 0xA3 arriving one cycle after rx_available
        uart.rx_available = 1'b1;
        tick();
        uart.rx_value = 8'hA3;
        check_val("rx_clr_early", 32'(uart.rx_clear), 32'h0);
        tick();
        check_val("rx_clr_set",  32'(uart.rx_clear), 32'h1);
        check_val("rx_dataA3",   32'(rd_data),        32'hA3);
        check_val("rx_nonempty", 32'(rx_empty),       32'h0);
        tick();
        check_val("rx_clr_hold", 32'(uart.rx_clear), 32'h1);
        uart.rx_available = 1'b0;
        tick();
        check_val("rx_clr_drop", 32'(uart.rx_clear), 32'h0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("rx_popped", 32'(rx_empty), 32'h1);

        // Read while empty is ignored
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("rd_empty_ign", 32'(rx_empty), 32'h1);
        rx_byte(8'h3C, 1'b0);
        check_val("rx_after_ign", 32'(rd_data), 32'h3C);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;

`ifdef UART_RX_FIFO_EN
        // Five bytes into a 4-deep FIFO: fifth dropped
        for (int i = 1; i <= 5; i++) begin
            rx_byte(8'(8'h10 + i), 1'b0);
        end
        check_val("ovr_set", 32'(overrun), 32'h1);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check_val("ovr_clr", 32'(overrun), 32'h0);
        rx_byte(8'h99, 1'b1);
        check_val("ovr_set_wins", 32'(overrun), 32'h1);
        for (int i = 1; i <= 4; i++) begin
            check_val("rx_fifo_order", 32'(rd_data), 32'(8'h10 + i));
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        check_val("rx_fifo_empty", 32'(rx_empty), 32'h1);
`else
        // Holding register: second byte dropped, first kept
        rx_byte(8'h11, 1'b0);
        check_val("hold_no_ovr", 32'(overrun), 32'h0);
        rx_byte(8'h22, 1'b0);
        check_val("hold_keep",  32'(rd_data),  32'h11);
        check_val("ovr_set",    32'(overrun),  32'h1);
        check_val("hold_full",  32'(rx_empty), 32'h0);
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;
        check_val("ovr_clr", 32'(overrun), 32'h0);
        rx_byte(8'h33, 1'b1);
        check_val("ovr_set_wins", 32'(overrun), 32'h1);
        check_val("hold_keep2",   32'(rd_data), 32'h11);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check_val("hold_empty", 32'(rx_empty), 32'h1);
`endif
        clear_overrun = 1'b1;
        tick();
        clear_overrun = 1'b0;

        // Reset while in T_SEND (full TX FIFO) and R_CLEAR
        wr_en = 1'b1;
        wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        tick();
        uart.rx_available = 1'b1;
        wr_en = 1'b1;
        wr_data = 8'h81;
        tick();
        uart.rx_value = 8'h5A;
        wr_data = 8'h82;
        tick();
        wr_data = 8'h83;
        tick();
        wr_data = 8'h84;
        tick();
        wr_en = 1'b0;
        check_val("pre_full",     32'(tx_full),        32'h1);
        check_val("pre_start",    32'(uart.start_tx),  32'h1);
        check_val("pre_rx_clear", 32'(uart.rx_clear),  32'h1);
        check_val("pre_rx_held",  32'(rx_empty),       32'h0);
        rst = 1'b1;
        tick();
        check_val("mid_rst_start",  32'(uart.start_tx), 32'h0);
        check_val("mid_rst_clear",  32'(uart.rx_clear), 32'h0);
        check_val("mid_rst_empty",  32'(rx_empty),      32'h1);
        check_val("mid_rst_full",   32'(tx_full),       32'h0);
        check_val("mid_rst_txval",  32'(uart.tx_value), 32'h0);
        check_val("mid_rst_rddata", 32'(rd_data),       32'h0);
        rst = 1'b0;
        uart.rx_available = 1'b0;
        tick();
        tick();
        check_val("post_rst_idle",  32'(uart.start_tx), 32'h0);
        check_val("post_rst_empty", 32'(rx_empty),      32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
